// File: rtl/dma_burst_gate.sv
// Burst-gated FIFO between the application DMA stream and the TLP transceiver DMA port.
// dmaValid_out only rises once a whole burst is buffered, then holds until that burst has been popped.
module dma_burst_gate #(
  parameter int DEPTH     = 7,
  parameter int BURST_QWS = 16
) (
  input  logic             pcieClk_in,
  input  logic             reset_in,
  input  logic [63:0]      appData_in,
  input  logic             appValid_in,
  output logic             appReady_out,
  output logic [63:0]      dmaData_out,
  output logic             dmaValid_out,
  input  logic             dmaReady_in,
  output logic [DEPTH:0]   depth_out,
  output logic             underflow_out
);

  // Handshakes: a QW moves on the app side when appValid_in & appReady_out, and
  // leaves on the DMA side when dmaReady_in is high and the FIFO is non-empty.
  localparam int             BEAT_W    = $clog2(BURST_QWS);
  localparam logic [DEPTH:0] FULL_CNT  = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] BURST_CNT = (DEPTH+1)'(BURST_QWS);

  typedef enum logic {
    ST_GATED = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  logic [63:0]       r_mem [0:(2**DEPTH)-1];
  logic [DEPTH-1:0]  r_wr_ptr;
  logic [DEPTH-1:0]  r_rd_ptr;
  logic [DEPTH:0]    r_count;
  logic [BEAT_W-1:0] r_beat;
  state_t            r_state;
  logic              r_underflow;

  logic              w_push;
  logic              w_pop;
  logic [DEPTH:0]    w_count_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;

  assign appReady_out  = (r_count != FULL_CNT);
  assign w_push        = appValid_in & appReady_out;
  assign w_pop         = dmaReady_in & (r_count != '0);
  assign dmaData_out   = r_mem[r_rd_ptr];
  assign depth_out     = r_count;
  assign underflow_out = r_underflow;
  assign dmaValid_out  = (r_state == ST_BURST) | (r_count >= BURST_CNT);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
    w_beat_nxt = r_beat;
    if (w_pop) begin
      w_beat_nxt = r_beat + 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge pcieClk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= appData_in;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_beat      <= '0;
      r_state     <= ST_GATED;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_beat  <= w_beat_nxt;
      // BURST lasts exactly until the beat counter wraps back to zero.
      r_state <= (w_beat_nxt != '0) ? ST_BURST : ST_GATED;
      if (dmaReady_in && (r_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
